// File: rtl/f_add_acc_if.sv
// Bundle of the Versat FU run-control, operand and result signals for f_add_acc.
// The master (datapath/bench) drives the controls and operands; the slave (the FU) returns out0/done.
interface f_add_acc_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              running;
  logic              run;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  acc_len;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] out0;
  logic              done;

  modport master (
    output running, run, mode, acc_len, in0, in1,
    input  out0, done
  );

  modport slave (
    input  running, run, mode, acc_len, in0, in1,
    output out0, done
  );
endinterface

// File: rtl/f_add_acc.sv
// Single-precision FP add/sub/accumulate unit around one fixed-latency FP adder core.
// Accumulation keeps ADD_LAT interleaved partial sums in flight, then folds them in lane order.
module iob_fp_add #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] res
);
  logic [31:0] sum_c;
  logic [31:0] pipe_reg [LAT];

  // IEEE-754 single add, round-to-nearest-even, subnormals kept, one canonical NaN.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sl, eff_sub, sticky, rup;
    logic        a_nan, b_nan;
    logic [7:0]  ea, eb;
    logic [9:0]  exa, exb, el, es, d, e_norm, e_out;
    logic [23:0] ma, mb, ml, msm;
    logic [53:0] sh;
    logic [26:0] big_x, small_x, m;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic [31:0] r;
    int          lz, shl;
    sa  = a[31];
    sb  = b[31];
    ea  = a[30:23];
    eb  = b[30:23];
    ma  = {|ea, a[22:0]};
    mb  = {|eb, b[22:0]};
    exa = (ea == 8'd0) ? 10'd1 : {2'b00, ea};
    exb = (eb == 8'd0) ? 10'd1 : {2'b00, eb};
    a_nan = (ea == 8'hFF) && (|a[22:0]);
    b_nan = (eb == 8'hFF) && (|b[22:0]);
    r = 32'd0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (a_nan || b_nan || (ea == 8'hFF && eb == 8'hFF && sa != sb))
        r = 32'h7FC0_0000;
      else if (ea == 8'hFF)
        r = {sa, 8'hFF, 23'd0};
      else
        r = {sb, 8'hFF, 23'd0};
    end else begin
      if ({exa, ma} >= {exb, mb}) begin
        sl = sa; el = exa; ml = ma; es = exb; msm = mb;
      end else begin
        sl = sb; el = exb; ml = mb; es = exa; msm = ma;
      end
      eff_sub = sa ^ sb;
      d = el - es;
      if (d > 10'd26) begin
        sh      = 54'd0;
        small_x = 27'd0;
        sticky  = |msm;
      end else begin
        sh      = {msm, 30'd0} >> d;
        small_x = sh[53:27];
        sticky  = |sh[26:0];
      end
      small_x[0] = small_x[0] | sticky;
      big_x = {ml, 3'b000};
      sum = eff_sub ? ({1'b0, big_x} - {1'b0, small_x}) : ({1'b0, big_x} + {1'b0, small_x});
      lz = 27;
      for (int i = 0; i < 27; i++)
        if (sum[i]) lz = 26 - i;
      if (sum == 28'd0) begin
        r = {eff_sub ? 1'b0 : sl, 31'd0};
      end else begin
        if (sum[27]) begin
          m      = {sum[27:2], sum[1] | sum[0]};
          e_norm = el + 10'd1;
        end else begin
          // Left shift stops at exponent 1 so tiny results land as subnormals.
          shl    = (lz > int'(el) - 1) ? int'(el) - 1 : lz;
          m      = sum[26:0] << shl;
          e_norm = m[26] ? (el - 10'(shl)) : 10'd0;
        end
        rup   = m[2] & (m[1] | m[0] | m[3]);
        rnd   = {1'b0, m[26:3]} + {24'd0, rup};
        e_out = e_norm + {9'd0, rnd[24]} + {9'd0, (e_norm == 10'd0) && rnd[23]};
        frac  = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (e_out >= 10'd255)
          r = {sl, 8'hFF, 23'd0};
        else
          r = {sl, e_out[7:0], frac};
      end
    end
    return r;
  endfunction

  always_comb sum_c = fp_add(op_a, op_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= sum_c;
      for (int i = 1; i < LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign res = pipe_reg[LAT-1];
endmodule

module f_add_acc #(
  parameter int DATA_W  = 32,
  parameter int ADD_LAT = 5,
  parameter int LEN_W   = 16
) (
  input logic       clk,
  input logic       rst,
  f_add_acc_if.slave bus
);
  localparam int               CW       = $clog2(ADD_LAT + 1);
  localparam logic [1:0]       MODE_SUB = 2'd1;
  localparam logic [1:0]       MODE_ACC = 2'd2;
  localparam logic [LEN_W-1:0] LAT_LEN  = LEN_W'(ADD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_REDUCE, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  k_reg, k_next;
  logic [CW-1:0]     dr_reg, dr_next;
  logic [CW-1:0]     ridx_reg, ridx_next;
  logic [CW-1:0]     rt_reg, rt_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic [DATA_W-1:0] part_reg [ADD_LAT];

  logic [DATA_W-1:0] op_a, op_b, core_out, red_b, live_b;
  logic [LEN_W-1:0]  n_last;
  logic              acc_start, any_run, cap_en, done_w;
  logic [CW-1:0]     cap_idx;

  iob_fp_add #(.LAT(ADD_LAT)) core (
    .clk  (clk),
    .rst  (rst),
    .op_a (op_a),
    .op_b (op_b),
    .res  (core_out)
  );

  assign any_run   = bus.run && bus.running;
  assign acc_start = any_run && (bus.mode == MODE_ACC);
  assign n_last    = (len_reg > LAT_LEN) ? (len_reg - 1'b1) : (LAT_LEN - 1'b1);
  assign live_b    = (bus.mode == MODE_SUB) ? {~bus.in1[DATA_W-1], bus.in1[DATA_W-2:0]} : bus.in1;

  // Second operand of a reduction step; with two lanes the only partner is still on the core output.
  always_comb begin
    red_b = '0;
    for (int i = 0; i < ADD_LAT; i++)
      if (ridx_reg == CW'(i)) red_b = part_reg[i];
    if (ADD_LAT == 2) red_b = core_out;
  end

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    k_next      = k_reg;
    dr_next     = dr_reg;
    ridx_next   = ridx_reg;
    rt_next     = rt_reg;
    result_next = result_reg;
    op_a        = bus.in0;
    op_b        = live_b;
    cap_en      = 1'b0;
    cap_idx     = dr_reg;
    case (state_reg)
      S_IDLE: begin
        if (acc_start) begin
          len_next   = bus.acc_len;
          k_next     = '0;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        op_a = (k_reg < len_reg) ? bus.in0 : '0;
        op_b = (k_reg < LAT_LEN) ? '0 : core_out;
        if (!bus.running) begin
          state_next = S_IDLE;
        end else begin
          k_next = k_reg + 1'b1;
          if (k_reg == n_last) begin
            dr_next    = '0;
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        op_a = '0;
        op_b = '0;
        if (!bus.running) begin
          state_next = S_IDLE;
        end else begin
          cap_en  = 1'b1;
          dr_next = dr_reg + 1'b1;
          if (dr_reg == CW'(ADD_LAT - 2)) begin
            ridx_next  = CW'(1);
            rt_next    = '0;
            state_next = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        op_a = '0;
        op_b = '0;
        if (!bus.running) begin
          state_next = S_IDLE;
        end else begin
          // The last lane's partial sum emerges on the first reduce cycle.
          if (ridx_reg == CW'(1) && rt_reg == '0) begin
            cap_en  = 1'b1;
            cap_idx = CW'(ADD_LAT - 1);
          end
          if (rt_reg == '0 && ridx_reg == CW'(ADD_LAT)) begin
            result_next = core_out;
            state_next  = S_DONE;
          end else begin
            if (rt_reg == '0) begin
              op_a = (ridx_reg == CW'(1)) ? part_reg[0] : core_out;
              op_b = red_b;
            end
            if (rt_reg == CW'(ADD_LAT - 1)) begin
              rt_next   = '0;
              ridx_next = ridx_reg + 1'b1;
            end else begin
              rt_next = rt_reg + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (acc_start) begin
          len_next   = bus.acc_len;
          k_next     = '0;
          state_next = S_STREAM;
        end else if (any_run) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      len_reg    <= '0;
      k_reg      <= '0;
      dr_reg     <= '0;
      ridx_reg   <= '0;
      rt_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      k_reg      <= k_next;
      dr_reg     <= dr_next;
      ridx_reg   <= ridx_next;
      rt_reg     <= rt_next;
      result_reg <= result_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++) part_reg[i] <= '0;
    end else begin
      for (int i = 0; i < ADD_LAT; i++)
        if (cap_en && cap_idx == CW'(i)) part_reg[i] <= core_out;
    end
  end

  // A restarting run drops done in the same cycle it is seen.
  assign done_w   = (state_reg == S_DONE) && !any_run;
  assign bus.done = done_w;
  assign bus.out0 = done_w ? result_reg
                  : (state_reg == S_IDLE && bus.running && bus.mode != MODE_ACC) ? core_out
                  : '0;
endmodule
